gmii_mux_nch_cpu_regs: RTL

//  AXI4-Lite register file for the N-input/M-output GMII mux. Holds one select register per output and
//  a 32-bit saturating frame counter per input, plus ID/VERSION/CTRL. Replaces the single-select block.

---
 rtl/gmii_mux_regs_pkg.sv | 54 +++++
 rtl/gmii_mux_stat_counter.sv | 30 +++
 rtl/gmii_mux_nch_cpu_regs.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/gmii_mux_regs_pkg.sv
// rtl/gmii_mux_regs_pkg.sv - register map constants and offset decode for the GMII mux CPU registers
// Contents: byte offsets, register stride, AXI response codes, unmapped read value,
//           register-kind decode of a word index.
package gmii_mux_regs_pkg;

    localparam int OFF_ID          = 'h00;
    localparam int OFF_VERSION     = 'h04;
    localparam int OFF_CTRL        = 'h08;
    localparam int OFF_SELECT_BASE = 'h10;
    localparam int OFF_COUNT_BASE  = 'h40;
    localparam int REG_STRIDE      = 4;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_ID,
        REG_VERSION,
        REG_CTRL,
        REG_SELECT,
        REG_COUNT
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [3:0] idx;
    } reg_hit_t;

    // widx is the offset within the low 256-byte window divided by the stride.
    function automatic reg_hit_t decode_word(input logic [5:0] widx, input int num_in, input int num_out);
        reg_hit_t hit;
        int       off;
        off      = int'(widx) * REG_STRIDE;
        hit.kind = REG_NONE;
        hit.idx  = '0;
        if (off == OFF_ID) begin
            hit.kind = REG_ID;
        end else if (off == OFF_VERSION) begin
            hit.kind = REG_VERSION;
        end else if (off == OFF_CTRL) begin
            hit.kind = REG_CTRL;
        end else if (off >= OFF_SELECT_BASE && off < OFF_SELECT_BASE + REG_STRIDE * num_out) begin
            hit.kind = REG_SELECT;
            hit.idx  = 4'((off - OFF_SELECT_BASE) / REG_STRIDE);
        end else if (off >= OFF_COUNT_BASE && off < OFF_COUNT_BASE + REG_STRIDE * num_in) begin
            hit.kind = REG_COUNT;
            hit.idx  = 4'((off - OFF_COUNT_BASE) / REG_STRIDE);
        end
        return hit;
    endfunction

endpackage

// File: rtl/gmii_mux_stat_counter.sv
// rtl/gmii_mux_stat_counter.sv - 32-bit saturating frame counter with clear and clear-on-snapshot
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset; inc count one frame;
//        clr unconditional clear (wins over inc); snap read snapshot clear (an inc in the
//        same cycle is kept, counter becomes 1); count current value.
module gmii_mux_stat_counter (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        inc,
    input  logic        clr,
    input  logic        snap,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (snap) begin
            count_q <= {31'd0, inc};
        end else if (inc && count_q != 32'hFFFFFFFF) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/gmii_mux_nch_cpu_regs.sv
// rtl/gmii_mux_nch_cpu_regs.sv - AXI4-Lite register file for the N-input/M-output GMII mux
// Ports: S_AXI_* AXI4-Lite slave (no PROT) on S_AXI_ACLK, async active-low S_AXI_ARESETN;
//        id_in/version_in ID and VERSION read values; frame_inc one pulse per input frame;
//        select_out NUM_OUT packed select fields (field k drives output k).
// Option: GMII_MUX_REGS_COR_EN makes COUNT[j] reads clear the counter.
module gmii_mux_nch_cpu_regs
    import gmii_mux_regs_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          NUM_IN             = 4,
    parameter int          NUM_OUT            = 2,
    parameter int          SEL_W              = 2,
    parameter int          SELECT_RESET       = 0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     id_in,
    input  logic [31:0]                     version_in,
    input  logic [NUM_IN-1:0]               frame_inc,
    output logic [NUM_OUT*SEL_W-1:0]        select_out
);

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] BASE = C_S_AXI_ADDR_WIDTH'(C_BASE_ADDRESS);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [SEL_W-1:0] sel_q [NUM_OUT];
    logic [31:0]      cnt   [NUM_IN];

    // ---------------- write channel ----------------
    logic                          awready_q, wready_q, aw_held, w_held, bvalid_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]                    wdata_b0_q;
    logic                          wstrb_b0_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_off;
    reg_hit_t                      wr_hit;
    logic                          wr_unmapped, wr_commit, ctrl_clr;

    assign wr_off      = awaddr_q ^ BASE;
    assign wr_hit      = decode_word(wr_off[7:2], NUM_IN, NUM_OUT);
    assign wr_unmapped = (|wr_off[C_S_AXI_ADDR_WIDTH-1:8]) || (wr_hit.kind == REG_NONE);
    assign wr_commit   = aw_held && w_held;
    assign ctrl_clr    = wr_commit && !wr_unmapped && wr_hit.kind == REG_CTRL && wstrb_b0_q && wdata_b0_q[0];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wdata_b0_q <= '0;
            wstrb_b0_q <= 1'b0;
        end else begin
            // Each half is accepted on its own; a held half blocks only its own channel
            // so the other half can still arrive and complete the pair.
            awready_q <= S_AXI_AWVALID && !awready_q && !aw_held && !bvalid_q;
            wready_q  <= S_AXI_WVALID && !wready_q && !w_held && !bvalid_q;
            if (awready_q && S_AXI_AWVALID) begin
                aw_held  <= 1'b1;
                awaddr_q <= S_AXI_AWADDR;
            end
            if (wready_q && S_AXI_WVALID) begin
                w_held     <= 1'b1;
                wdata_b0_q <= S_AXI_WDATA[7:0];
                wstrb_b0_q <= S_AXI_WSTRB[0];
            end
            if (wr_commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_unmapped ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Out-of-range select values are acknowledged but ignored.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_OUT; k++) sel_q[k] <= SEL_W'(SELECT_RESET);
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_commit && !wr_unmapped && wr_hit.kind == REG_SELECT && int'(wr_hit.idx) == k &&
                    wstrb_b0_q && int'(wdata_b0_q) < NUM_IN) begin
                    sel_q[k] <= wdata_b0_q[SEL_W-1:0];
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;

    // ---------------- read channel ----------------
    logic [1:0]                    rd_state;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] rd_off;
    reg_hit_t                      rd_hit;
    logic                          rd_unmapped, ar_accept;
    logic [31:0]                   rd_word;

    assign rd_off      = S_AXI_ARADDR ^ BASE;
    assign rd_hit      = decode_word(rd_off[7:2], NUM_IN, NUM_OUT);
    assign rd_unmapped = (|rd_off[C_S_AXI_ADDR_WIDTH-1:8]) || (rd_hit.kind == REG_NONE);
    assign ar_accept   = (rd_state == R_ADDR) && S_AXI_ARVALID;

    always_comb begin
        rd_word = DEFAULT_RDATA;
        if (!rd_unmapped) begin
            case (rd_hit.kind)
                REG_ID:      rd_word = id_in;
                REG_VERSION: rd_word = version_in;
                REG_CTRL:    rd_word = 32'd0;
                REG_SELECT: begin
                    for (int k = 0; k < NUM_OUT; k++)
                        if (int'(rd_hit.idx) == k) rd_word = 32'(sel_q[k]);
                end
                REG_COUNT: begin
                    for (int j = 0; j < NUM_IN; j++)
                        if (int'(rd_hit.idx) == j) rd_word = cnt[j];
                end
                default:     rd_word = DEFAULT_RDATA;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: if (S_AXI_ARVALID) rd_state <= R_ADDR;
                R_ADDR: begin
                    if (ar_accept) begin
                        rd_state <= R_DATA;
                        rdata_q  <= rd_word;
                        rresp_q  <= rd_unmapped ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        rd_state <= R_IDLE;
                    end
                end
                R_DATA: if (S_AXI_RREADY) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_ARREADY = (rd_state == R_ADDR);
    assign S_AXI_RVALID  = (rd_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // ---------------- counters and select outputs ----------------
    for (genvar j = 0; j < NUM_IN; j++) begin : g_cnt
        logic snap;
`ifdef GMII_MUX_REGS_COR_EN
        assign snap = ar_accept && !rd_unmapped && rd_hit.kind == REG_COUNT && int'(rd_hit.idx) == j;
`else
        assign snap = 1'b0;
`endif
        gmii_mux_stat_counter u_cnt (
            .S_AXI_ACLK    (S_AXI_ACLK),
            .S_AXI_ARESETN (S_AXI_ARESETN),
            .inc           (frame_inc[j]),
            .clr           (ctrl_clr),
            .snap          (snap),
            .count         (cnt[j])
        );
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_sel
        assign select_out[k*SEL_W +: SEL_W] = sel_q[k];
    end

    // Only byte lane 0 carries register bits; address bits [1:0] do not select a register.
    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:8], S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1],
                         rd_off[1:0], wr_off[1:0]};

endmodule
